// File: rtl/div_sequencer_pkg.sv
// Shared constants and types for the EX-stage divider.
//   div_state_e      : sequencer state encoding
//   DIV_RESULT_W     : width of the {remainder, quotient} result bus
//   DIV/DIVU_CONTROL : function codes the hazard unit decodes to raise start
package div_sequencer_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam int DIV_RESULT_W = 64;

  localparam logic [5:0] DIV_CONTROL  = 6'b011010;
  localparam logic [5:0] DIVU_CONTROL = 6'b011011;

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring-division iteration, purely combinational.
//   i_rem     : partial remainder (always < i_divisor)
//   i_quo     : dividend bits still to shift in, quotient bits shifted in below
//   i_divisor : divisor magnitude
//   o_rem     : next partial remainder
//   o_quo     : next dividend/quotient shift register
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;

  // Shift the next dividend bit into the remainder; one extra bit so the
  // borrow of the trial subtract lands in the MSB.
  assign w_trial = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, i_divisor};

  always_comb begin
    if (!w_diff[WIDTH]) begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_trial[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for the EX stage.
//   clk        : core clock, rising edge
//   rst        : asynchronous reset, active high
//   start      : division request from the hazard unit
//   signed_div : 1 = DIV, 0 = DIVU, sampled with start in IDLE
//   opdata1    : dividend, sampled in IDLE
//   opdata2    : divisor, sampled in IDLE
//   annul      : exception flush, abandons any operation
//   hold       : EX stalled elsewhere, keep presenting the result
//   result     : {remainder, quotient} -> {HI, LO}
//   ready      : result valid
// Takes 32 iteration cycles; divide-by-zero short-circuits to a zero result.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  input  logic               hold,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_quo;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_rem;
  logic               r_quo_neg;
  logic               r_rem_neg;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic               w_s1;
  logic               w_s2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_step_quo;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Magnitudes wrap on WIDTH bits: the most negative value stays as its
  // unsigned magnitude, which is what makes MIN/-1 come out as MIN.
  assign w_s1   = signed_div & opdata1[WIDTH-1];
  assign w_s2   = signed_div & opdata2[WIDTH-1];
  assign w_mag1 = w_s1 ? (~opdata1 + 1'b1) : opdata1;
  assign w_mag2 = w_s2 ? (~opdata2 + 1'b1) : opdata2;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  // Sign fix-up is applied to the final step's output so the result is
  // registered on the same edge that enters END.
  assign w_quo_fix = r_quo_neg ? (~w_step_quo + 1'b1) : w_step_quo;
  assign w_rem_fix = r_rem_neg ? (~w_step_rem + 1'b1) : w_step_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= DIV_IDLE;
      r_cnt     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else if (annul) begin
      // Flush wins everywhere; the last completed result is left in place.
      r_state <= DIV_IDLE;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          r_ready <= 1'b0;
          if (start) begin
            if (opdata2 == '0) begin
              r_state <= DIV_BYZERO;
            end else begin
              r_state   <= DIV_ON;
              r_quo     <= w_mag1;
              r_divisor <= w_mag2;
              r_quo_neg <= w_s1 ^ w_s2;
              r_rem_neg <= w_s1;
              r_cnt     <= '0;
              r_rem     <= '0;
            end
          end
        end
        DIV_BYZERO: begin
          r_state  <= DIV_END;
          r_result <= '0;
          r_ready  <= 1'b1;
        end
        DIV_ON: begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_result <= {w_rem_fix, w_quo_fix};
            r_ready  <= 1'b1;
            r_state  <= DIV_END;
          end
        end
        DIV_END: begin
          if (!hold) begin
            r_state <= DIV_IDLE;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= DIV_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign result = r_result;
  assign ready  = r_ready;

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized self-checking bench for div_sequencer against an arithmetic
// reference of signed/unsigned division.
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        hold;
  logic [63:0] result;
  logic        ready;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] last_res = 64'd0;

  div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .hold       (hold),
    .result     (result),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // {remainder, quotient}; quotient truncates toward zero, remainder takes
  // the dividend's sign. Computed in 64 bits and wrapped to 32.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa - q * sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int nhold);
    logic [63:0] exp;
    int lat;
    int exp_lat;
    exp     = ref_div(sgn, a, b);
    exp_lat = (b == 32'd0) ? 1 : 32;
    @(negedge clk);
    start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    // Operands scrambled while busy: the divider must use the sampled ones.
    while (!ready && lat < 40) begin
      opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("result", result, exp);
    hold = (nhold > 0);
    for (int i = 0; i < nhold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_ready", 64'(ready), 64'd1);
      chk("hold_result", result, exp);
    end
    hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_ready", 64'(ready), 64'd0);
    chk("kept_result", result, exp);
    last_res = exp;
  endtask

  task automatic watch_no_ready(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) hits++;
    end
    chk(tag, 64'(hits), 64'd0);
    chk({tag, "_res"}, result, last_res);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
    annul = 1'b0; hold = 1'b0;
    #12;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner cases
    run_div(1'b0, 32'd100, 32'd7, 0);
    chk("u100_7", last_res, 64'h00000002_0000000E);
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 0);
    chk("s_m7_2", last_res, 64'hFFFFFFFF_FFFFFFFD);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("s_ovf", last_res, 64'h00000000_80000000);
    run_div(1'b0, 32'd1234, 32'd0, 0);
    run_div(1'b1, 32'hDEADBEEF, 32'd0, 1);

    // Flush at the 10th busy cycle: nothing completes, result untouched
    run_div(1'b0, 32'd55, 32'd4, 0);
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    chk("annul_ready", 64'(ready), 64'd0);
    watch_no_ready("annul_quiet", 40);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 0);
    chk("u_max_1", last_res, 64'h00000000_FFFFFFFF);

    // Flush coincident with start in IDLE: the request is dropped
    @(negedge clk);
    start = 1'b1; annul = 1'b1; opdata1 = 32'd9; opdata2 = 32'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    watch_no_ready("annul_start", 40);

    // Hold in END
    run_div(1'b1, 32'd77, 32'hFFFFFFF6, 3);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd5000; opdata2 = 32'd13;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    start = 1'b0;
    #1;
    chk("async_rst_ready", 64'(ready), 64'd0);
    chk("async_rst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_res = 64'd0;
    run_div(1'b0, 32'd5000, 32'd13, 0);

    // Random operations with occasional corner operands
    for (int k = 0; k < 30; k++) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'd1;
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; s = 1'b1; end
        3: b = $urandom_range(1, 20);
        4: b = 32'hFFFFFFFF;
        default: ;
      endcase
      run_div(s, a, b, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
